// File: rtl/data_mem_bridge_pkg.sv
// Shared constants for the MEM-stage data-memory bridge.
package data_mem_bridge_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  // FSM encodings kept as plain 2-bit constants so older code can match on them.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Word accesses only: both low address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_bridge_timeout_counter.sv
// Counts stalled cycles of one bus access; flags when the limit is reached.
module data_mem_bridge_timeout_counter #(
  parameter int TW    = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt;

  assign expired = (cnt == TW'(LIMIT));

  // Clear has priority; the count parks at LIMIT rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/data_mem_bridge.sv
// MEM-stage bridge: one req/ack bus transaction per load/store, freezes the
// pipeline through mem_stall while the transaction is outstanding.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_r,
  input  logic          mem_w,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          mem_stall,
  output logic          addr_err,
  output logic          bus_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic [31:0]   stall_cnt
);

  logic [1:0] state;
  logic       req, aligned, start, expired;

  assign req     = mem_r | mem_w;
  assign aligned = is_aligned(addr[1:0]);
  assign start   = (state == S_IDLE) && req && aligned;

  // Stall starts in the accepting IDLE cycle so the pipeline never advances
  // past an access; gated by reset so it drops with no clock edge.
  assign mem_stall = rst & (start | (state == S_WAIT));

  // Counter runs across the IDLE start cycle too, so the first WAIT cycle
  // sees count 1 and expiry at TIMEOUT means TIMEOUT WAIT cycles.
  data_mem_bridge_timeout_counter #(
    .TW    (TW),
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (~mem_stall),
    .en      (mem_stall),
    .expired (expired)
  );

  // FSM, bus-side registers, result and error pulses, stall statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rdata     <= '0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      stall_cnt <= '0;
    end else begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      if (mem_stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      case (state)
        S_IDLE: begin
          if (req && !aligned) begin
            addr_err <= 1'b1;
            rdata    <= '0;
          end else if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_w;  // read+write together is a write
            bus_addr  <= {addr[AW-1:2], 2'b00};
            bus_wdata <= wdata;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) rdata <= bus_rdata;
            state   <= S_DONE;
          end else if (expired) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            rdata   <= '0;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge (TIMEOUT=4 so the timeout path is short).
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r, mem_w;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        mem_stall, addr_err, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  data_mem_bridge #(
    .AW(32), .DW(32), .TIMEOUT(4), .TW(8)
  ) dut (
    .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .rdata(rdata), .mem_stall(mem_stall), .addr_err(addr_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Stimulus driver: called at posedge+1. Cycle 0 is the IDLE accept cycle,
  // cycle k is the k-th WAIT cycle; ack_at=0 means never ack. Returns at the
  // negedge of the first non-stalled cycle (DONE), with a 50-cycle bound.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int ack_at, input logic [31:0] rd,
                           output int stalls, output logic seen_berr,
                           output logic [31:0] b_addr, output logic b_we,
                           output logic [31:0] b_wdata, output logic seen_req);
    mem_r = r; mem_w = w; addr = a; wdata = d;
    stalls = 0; seen_berr = 1'b0; seen_req = 1'b0;
    b_addr = '0; b_we = 1'b0; b_wdata = '0;
    for (int c = 0; c < 50; c++) begin
      bus_ack   = (ack_at != 0) && (c == ack_at);
      bus_rdata = bus_ack ? rd : 32'hDEAD_BEEF;
      @(negedge clk);
      if (bus_req) seen_req = 1'b1;
      if (bus_err) seen_berr = 1'b1;
      if (c == 1) begin b_addr = bus_addr; b_we = bus_we; b_wdata = bus_wdata; end
      if (mem_stall) stalls++;
      else break;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; mem_r = 1'b1; mem_w = 1'b0; addr = 32'h10; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #12;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", mem_stall); end
    checks++; if ({bus_req, bus_we, addr_err, bus_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {bus_req, bus_we, addr_err, bus_err}); end
    checks++; if ({rdata, bus_addr, bus_wdata, stall_cnt} !== 128'h0) begin errors++; $display("FAIL reset_words got %h want 0", {rdata, bus_addr, bus_wdata, stall_cnt}); end
    mem_r = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read;
    int s; logic be, bw, sr; logic [31:0] ba, bd;
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678, s, be, ba, bw, bd, sr);
    checks++; if (s != 4) begin errors++; $display("FAIL read_stalls got %0d want 4", s); end
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL read_rdata got %h want 12345678", rdata); end
    checks++; if (ba !== 32'h10 || bw !== 1'b0 || !sr) begin errors++; $display("FAIL read_bus got addr %h we %b req %b want 10 0 1", ba, bw, sr); end
    checks++; if (bus_req !== 1'b0 || be !== 1'b0) begin errors++; $display("FAIL read_done got req %b berr %b want 0 0", bus_req, be); end
    @(posedge clk); #1; mem_r = 1'b0;
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL read_stallcnt got %0d want 4", stall_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    int s; logic be, bw, sr; logic [31:0] ba, bd;
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'h0, s, be, ba, bw, bd, sr);
    checks++; if (s != 2) begin errors++; $display("FAIL write_stalls got %0d want 2", s); end
    checks++; if (ba !== 32'h20 || bw !== 1'b1 || bd !== 32'hCAFE_F00D) begin errors++; $display("FAIL write_bus got addr %h we %b data %h want 20 1 cafef00d", ba, bw, bd); end
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL write_rdata got %h want 12345678", rdata); end
    @(posedge clk); #1; mem_w = 1'b0;
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL write_stallcnt got %0d want 6", stall_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned;
    mem_r = 1'b1; mem_w = 1'b0; addr = 32'h0000_0013;
    @(negedge clk);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %b want 0", mem_stall); end
    @(posedge clk); #1; mem_r = 1'b0;
    @(negedge clk);
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b want 1", addr_err); end
    checks++; if (rdata !== 32'h0 || bus_req !== 1'b0) begin errors++; $display("FAIL mis_rdata got rdata %h req %b want 0 0", rdata, bus_req); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (addr_err !== 1'b0 || stall_cnt !== 32'd6) begin errors++; $display("FAIL mis_after got aerr %b cnt %0d want 0 6", addr_err, stall_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int s1, s2; logic be, bw1, bw2, sr1, sr2; logic [31:0] ba1, ba2, bd;
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'hA5A5_0001, s1, be, ba1, bw1, bd, sr1);
    checks++; if (rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_rdata got %h want a5a50001", rdata); end
    @(posedge clk); #1;
    do_access(1'b0, 1'b1, 32'h0000_0044, 32'h5555_AAAA, 1, 32'h0, s2, be, ba2, bw2, bd, sr2);
    checks++; if (s1 != 2 || s2 != 2) begin errors++; $display("FAIL b2b_stalls got %0d %0d want 2 2", s1, s2); end
    checks++; if (ba1 !== 32'h40 || bw1 !== 1'b0 || ba2 !== 32'h44 || bw2 !== 1'b1 || !sr1 || !sr2) begin
      errors++; $display("FAIL b2b_bus got %h/%b %h/%b want 40/0 44/1", ba1, bw1, ba2, bw2); end
    @(posedge clk); #1; mem_w = 1'b0;
    @(negedge clk);
    checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL b2b_stallcnt got %0d want 10", stall_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int s; logic be, bw, sr; logic [31:0] ba, bd;
    do_access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, 32'h0, s, be, ba, bw, bd, sr);
    checks++; if (s != 5) begin errors++; $display("FAIL tmo_stalls got %0d want 5", s); end
    checks++; if (be !== 1'b1 || rdata !== 32'h0 || bus_req !== 1'b0) begin errors++; $display("FAIL tmo_done got berr %b rdata %h req %b want 1 0 0", be, rdata, bus_req); end
    @(posedge clk); #1; mem_r = 1'b0;
    @(negedge clk);
    checks++; if (bus_err !== 1'b0 || mem_stall !== 1'b0 || stall_cnt !== 32'd15) begin errors++; $display("FAIL tmo_after got berr %b stall %b cnt %0d want 0 0 15", bus_err, mem_stall, stall_cnt); end
    // Only IDLE raises stall in the same cycle a request appears.
    mem_r = 1'b1; addr = 32'h80; #1;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL tmo_idle got %b want 1", mem_stall); end
    mem_r = 1'b0;
    @(posedge clk); #1;
    // Ack lands in the same cycle the limit is hit: ack wins.
    do_access(1'b1, 1'b0, 32'h0000_0084, 32'h0, 4, 32'h0BAD_F00D, s, be, ba, bw, bd, sr);
    checks++; if (s != 5 || be !== 1'b0 || rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL tmo_ackwins got stalls %0d berr %b rdata %h want 5 0 0badf00d", s, be, rdata); end
    @(posedge clk); #1; mem_r = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int s; logic be, bw, sr; logic [31:0] ba, bd;
    mem_r = 1'b1; mem_w = 1'b0; addr = 32'h100; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b1 || mem_stall !== 1'b1) begin errors++; $display("FAIL arst_pre got req %b stall %b want 1 1", bus_req, mem_stall); end
    #2 rst = 1'b0; #1;
    checks++; if (bus_req !== 1'b0 || mem_stall !== 1'b0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL arst_drop got req %b stall %b cnt %0d want 0 0 0", bus_req, mem_stall, stall_cnt); end
    mem_r = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1, 32'h7777_0000, s, be, ba, bw, bd, sr);
    checks++; if (s != 2 || rdata !== 32'h7777_0000) begin errors++; $display("FAIL arst_idle got stalls %0d rdata %h want 2 77770000", s, rdata); end
    @(posedge clk); #1; mem_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
